// File: rtl/ghost_collision_monitor.sv
// Ghost/player collision monitor: detects overlap and swap collisions on each
// move_tick, counts lives, and sequences the freeze/respawn/game-over states.
module ghost_collision_monitor #(
    parameter int NUM_GHOSTS   = 4,
    parameter int START_LIVES  = 3,
    parameter int FREEZE_TICKS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    move_tick,
    input  logic [9:0]              player_x,
    input  logic [8:0]              player_y,
    input  logic [10*NUM_GHOSTS-1:0] ghost_x,
    input  logic [9*NUM_GHOSTS-1:0]  ghost_y,
    input  logic                    restart,
    output logic                    hit,
    output logic [1:0]              hit_ghost,
    output logic [1:0]              lives,
    output logic                    freeze,
    output logic                    respawn,
    output logic                    game_over
);

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        HIT  = 2'd1,
        OVER = 2'd2
    } state_e;

    localparam logic [1:0] LIVES_INIT  = 2'(START_LIVES);
    localparam logic [3:0] FREEZE_INIT = 4'(FREEZE_TICKS);

    state_e                    state_q, state_d;
    logic [1:0]                lives_q, lives_d;
    logic [1:0]                hit_ghost_q, hit_ghost_d;
    logic [3:0]                freeze_cnt_q, freeze_cnt_d;
    logic                      hit_q, hit_d;
    logic                      respawn_q, respawn_d;
    logic                      freeze_q, freeze_d;
    logic                      game_over_q, game_over_d;
    logic                      prev_valid_q, prev_valid_d;
    logic [9:0]                prev_px_q, prev_px_d;
    logic [8:0]                prev_py_q, prev_py_d;
    logic [10*NUM_GHOSTS-1:0]  prev_gx_q, prev_gx_d;
    logic [9*NUM_GHOSTS-1:0]   prev_gy_q, prev_gy_d;

    logic [NUM_GHOSTS-1:0]     collide;
    logic [1:0]                hit_idx;
    logic                      any_hit;

    // A swap means the ghost and player exchanged tiles between two ticks,
    // which an overlap test alone would miss.
    always_comb begin
        collide = '0;
        for (int i = 0; i < NUM_GHOSTS; i++) begin
            collide[i] = ((ghost_x[10*i +: 10] == player_x) &&
                          (ghost_y[9*i +: 9]   == player_y)) ||
                         (prev_valid_q &&
                          (ghost_x[10*i +: 10]   == prev_px_q) &&
                          (ghost_y[9*i +: 9]     == prev_py_q) &&
                          (prev_gx_q[10*i +: 10] == player_x) &&
                          (prev_gy_q[9*i +: 9]   == player_y));
        end
    end

    // Scanning downward lets the lowest colliding index win.
    always_comb begin
        hit_idx = '0;
        for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
            if (collide[i]) begin
                hit_idx = 2'(i);
            end
        end
    end

    assign any_hit = |collide;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through
        // the case statement leaves it unassigned and infers a latch.
        state_d      = state_q;
        lives_d      = lives_q;
        hit_ghost_d  = hit_ghost_q;
        freeze_cnt_d = freeze_cnt_q;
        hit_d        = 1'b0;
        respawn_d    = 1'b0;
        freeze_d     = freeze_q;
        game_over_d  = game_over_q;
        prev_valid_d = prev_valid_q;
        prev_px_d    = prev_px_q;
        prev_py_d    = prev_py_q;
        prev_gx_d    = prev_gx_q;
        prev_gy_d    = prev_gy_q;

        if (restart) begin
            state_d      = PLAY;
            lives_d      = LIVES_INIT;
            freeze_cnt_d = '0;
            respawn_d    = 1'b1;
            freeze_d     = 1'b0;
            game_over_d  = 1'b0;
            prev_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                PLAY: begin
                    if (move_tick) begin
                        prev_valid_d = 1'b1;
                        prev_px_d    = player_x;
                        prev_py_d    = player_y;
                        prev_gx_d    = ghost_x;
                        prev_gy_d    = ghost_y;
                        if (any_hit) begin
                            hit_d       = 1'b1;
                            hit_ghost_d = hit_idx;
                            freeze_d    = 1'b1;
                            lives_d     = (lives_q == 2'd0) ? 2'd0 : lives_q - 2'd1;
                            if (lives_q <= 2'd1) begin
                                state_d     = OVER;
                                game_over_d = 1'b1;
                            end else begin
                                state_d      = HIT;
                                freeze_cnt_d = FREEZE_INIT;
                            end
                        end
                    end
                end
                HIT: begin
                    freeze_d = 1'b1;
                    if (move_tick) begin
                        if (freeze_cnt_q <= 4'd1) begin
                            freeze_cnt_d = '0;
                            respawn_d    = 1'b1;
                            prev_valid_d = 1'b0;
                            freeze_d     = 1'b0;
                            state_d      = PLAY;
                        end else begin
                            freeze_cnt_d = freeze_cnt_q - 4'd1;
                        end
                    end
                end
                OVER: begin
                    freeze_d    = 1'b1;
                    game_over_d = 1'b1;
                end
                default: begin
                    state_d = PLAY;
                end
            endcase
        end
    end

    // NOTE: the previous-position registers are reset too, so a stale swap
    // match can never fire from power-up contents.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= PLAY;
            lives_q      <= LIVES_INIT;
            hit_ghost_q  <= '0;
            freeze_cnt_q <= '0;
            hit_q        <= 1'b0;
            respawn_q    <= 1'b0;
            freeze_q     <= 1'b0;
            game_over_q  <= 1'b0;
            prev_valid_q <= 1'b0;
            prev_px_q    <= '0;
            prev_py_q    <= '0;
            prev_gx_q    <= '0;
            prev_gy_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling the
            // pre-edge values, independent of statement order.
            state_q      <= state_d;
            lives_q      <= lives_d;
            hit_ghost_q  <= hit_ghost_d;
            freeze_cnt_q <= freeze_cnt_d;
            hit_q        <= hit_d;
            respawn_q    <= respawn_d;
            freeze_q     <= freeze_d;
            game_over_q  <= game_over_d;
            prev_valid_q <= prev_valid_d;
            prev_px_q    <= prev_px_d;
            prev_py_q    <= prev_py_d;
            prev_gx_q    <= prev_gx_d;
            prev_gy_q    <= prev_gy_d;
        end
    end

    assign hit       = hit_q;
    assign hit_ghost = hit_ghost_q;
    assign lives     = lives_q;
    assign freeze    = freeze_q;
    assign respawn   = respawn_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_ghost_collision_monitor.sv
// Scoreboard bench for ghost_collision_monitor: a behavioural model predicts
// each cycle's registered outputs, which are queued and compared after the edge.
module tb_ghost_collision_monitor;

    localparam int NG = 4;
    localparam int SL = 3;
    localparam int FT = 3;

    logic            clk;
    logic            reset;
    logic            move_tick;
    logic [9:0]      player_x;
    logic [8:0]      player_y;
    logic [10*NG-1:0] ghost_x;
    logic [9*NG-1:0]  ghost_y;
    logic            restart;
    logic            hit;
    logic [1:0]      hit_ghost;
    logic [1:0]      lives;
    logic            freeze;
    logic            respawn;
    logic            game_over;

    logic [9:0] gx [NG];
    logic [8:0] gy [NG];

    for (genvar g = 0; g < NG; g++) begin : g_pack
        assign ghost_x[10*g +: 10] = gx[g];
        assign ghost_y[9*g +: 9]   = gy[g];
    end

    ghost_collision_monitor #(
        .NUM_GHOSTS  (NG),
        .START_LIVES (SL),
        .FREEZE_TICKS(FT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .move_tick (move_tick),
        .player_x  (player_x),
        .player_y  (player_y),
        .ghost_x   (ghost_x),
        .ghost_y   (ghost_y),
        .restart   (restart),
        .hit       (hit),
        .hit_ghost (hit_ghost),
        .lives     (lives),
        .freeze    (freeze),
        .respawn   (respawn),
        .game_over (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int e_hit;
        int e_hg;
        int e_lives;
        int e_freeze;
        int e_respawn;
        int e_go;
    } exp_t;

    exp_t sb [$];

    int checks = 0;
    int errors = 0;

    // Reference model: 0 = playing, 1 = frozen after a hit, 2 = game over.
    int m_state, m_lives, m_cnt, m_hg, m_freeze, m_go;
    bit m_pv;
    int m_ppx, m_ppy;
    int m_pgx [NG];
    int m_pgy [NG];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_lives = SL; m_cnt = 0; m_hg = 0; m_freeze = 0; m_go = 0;
        m_pv = 0; m_ppx = 0; m_ppy = 0;
        for (int i = 0; i < NG; i++) begin
            m_pgx[i] = 0;
            m_pgy[i] = 0;
        end
    endtask

    task automatic model_step(input bit rs, input bit tk, output exp_t e);
        int coll;
        e.e_hit = 0;
        e.e_respawn = 0;
        if (rs) begin
            m_state = 0; m_lives = SL; m_cnt = 0; m_pv = 0;
            m_freeze = 0; m_go = 0; e.e_respawn = 1;
        end else if (m_state == 0 && tk) begin
            coll = -1;
            for (int i = 0; i < NG; i++) begin
                if (coll < 0) begin
                    if (int'(gx[i]) == int'(player_x) && int'(gy[i]) == int'(player_y))
                        coll = i;
                    else if (m_pv && int'(gx[i]) == m_ppx && int'(gy[i]) == m_ppy &&
                             m_pgx[i] == int'(player_x) && m_pgy[i] == int'(player_y))
                        coll = i;
                end
            end
            m_pv = 1; m_ppx = int'(player_x); m_ppy = int'(player_y);
            for (int i = 0; i < NG; i++) begin
                m_pgx[i] = int'(gx[i]);
                m_pgy[i] = int'(gy[i]);
            end
            if (coll >= 0) begin
                e.e_hit = 1; m_hg = coll; m_lives = m_lives - 1; m_freeze = 1;
                if (m_lives == 0) begin
                    m_state = 2; m_go = 1;
                end else begin
                    m_state = 1; m_cnt = FT;
                end
            end
        end else if (m_state == 1 && tk) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_state = 0; e.e_respawn = 1; m_pv = 0; m_freeze = 0;
            end
        end
        e.e_hg = m_hg;
        e.e_lives = m_lives;
        e.e_freeze = m_freeze;
        e.e_go = m_go;
    endtask

    task automatic cycle(input int px, input int py, input bit tk, input bit rs);
        exp_t e;
        @(negedge clk);
        player_x  = 10'(px);
        player_y  = 9'(py);
        move_tick = tk;
        restart   = rs;
        model_step(rs, tk, e);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("hit",       32'(hit),       32'(e.e_hit));
        check("hit_ghost", 32'(hit_ghost), 32'(e.e_hg));
        check("lives",     32'(lives),     32'(e.e_lives));
        check("freeze",    32'(freeze),    32'(e.e_freeze));
        check("respawn",   32'(respawn),   32'(e.e_respawn));
        check("game_over", 32'(game_over), 32'(e.e_go));
    endtask

    task automatic park();
        for (int i = 0; i < NG; i++) begin
            gx[i] = 10'(500 + 20 * i);
            gy[i] = 9'd460;
        end
    endtask

    initial begin
        reset = 1'b0; move_tick = 1'b0; restart = 1'b0;
        player_x = '0; player_y = '0;
        park();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_hit",       32'(hit),       0);
        check("rst_hit_ghost", 32'(hit_ghost), 0);
        check("rst_lives",     32'(lives),     SL);
        check("rst_freeze",    32'(freeze),    0);
        check("rst_respawn",   32'(respawn),   0);
        check("rst_game_over", 32'(game_over), 0);
        @(negedge clk);
        reset = 1'b1;

        // Near miss: no collision.
        gx[0] = 10'd20; gy[0] = 9'd160;
        cycle(100, 100, 1, 0);
        check("miss_hit", 32'(hit), 0);
        park();

        // Overlap ignored without a tick, then caught on the tick.
        gx[2] = 10'd140; gy[2] = 9'd160;
        cycle(140, 160, 0, 0);
        cycle(140, 160, 1, 0);
        check("ovl_hit_ghost", 32'(hit_ghost), 2);
        check("ovl_lives",     32'(lives),     2);
        check("ovl_freeze",    32'(freeze),    1);
        cycle(140, 160, 0, 0);
        cycle(140, 160, 1, 0);
        cycle(140, 160, 1, 0);
        cycle(140, 160, 0, 0);
        cycle(140, 160, 1, 0);
        check("frz_respawn", 32'(respawn), 1);
        park();

        // Swap collision with ghost 1.
        gx[1] = 10'd220; gy[1] = 9'd240;
        cycle(200, 240, 1, 0);
        gx[1] = 10'd200;
        cycle(220, 240, 1, 0);
        check("swap_hit",       32'(hit),       1);
        check("swap_hit_ghost", 32'(hit_ghost), 1);
        repeat (3) cycle(220, 240, 1, 0);
        park();
        cycle(0, 0, 0, 1);
        check("restart_lives", 32'(lives), SL);

        // Two ghosts overlap at once: lowest index wins, one pulse.
        gx[1] = 10'd60; gy[1] = 9'd80;
        gx[3] = 10'd60; gy[3] = 9'd80;
        cycle(60, 80, 1, 0);
        check("multi_hit_ghost", 32'(hit_ghost), 1);
        repeat (3) cycle(60, 80, 1, 0);
        check("multi_respawn", 32'(respawn), 1);
        check("multi_freeze",  32'(freeze),  0);

        // Run out of lives, then restart together with a tick.
        cycle(60, 80, 1, 0);
        repeat (3) cycle(60, 80, 1, 0);
        cycle(60, 80, 1, 0);
        check("over_lives",     32'(lives),     0);
        check("over_game_over", 32'(game_over), 1);
        repeat (2) cycle(60, 80, 1, 0);
        check("over_no_hit", 32'(hit), 0);
        cycle(60, 80, 1, 1);
        check("rs_tick_hit",     32'(hit),       0);
        check("rs_tick_respawn", 32'(respawn),   1);
        check("rs_tick_lives",   32'(lives),     SL);
        check("rs_tick_go",      32'(game_over), 0);

        // Reset in the middle of a freeze.
        cycle(60, 80, 1, 0);
        cycle(60, 80, 1, 0);
        #2;
        reset = 1'b0; move_tick = 1'b0; restart = 1'b0;
        #1;
        check("mid_rst_freeze",  32'(freeze),  0);
        check("mid_rst_lives",   32'(lives),   SL);
        check("mid_rst_respawn", 32'(respawn), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        park();
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // Random play on a tiny grid to exercise swaps, ties and restarts.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NG; i++) begin
                gx[i] = 10'(20 * $urandom_range(2));
                gy[i] = 9'(20 * $urandom_range(1));
            end
            cycle(20 * int'($urandom_range(2)), 20 * int'($urandom_range(1)),
                  bit'($urandom_range(9) < 6), bit'($urandom_range(29) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
